// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline definitions for the register-file write path.
//               Provides the data width, the register-address width, the
//               register count and the write-request record used to describe
//               a single register-file write.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One register-file write: destination, value and enable.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  we;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Parameterised synchronous FIFO for buffered writeback results.
//               The head entry is always visible on head_data, so a consumer
//               can use it in the same cycle it decides to pop.
// Ports       : clk, rst_n      - clock, async active-low reset
//               push, push_data - write an entry (ignored when full)
//               pop             - remove the head entry (ignored when empty)
//               head_data       - current head entry
//               full, empty     - occupancy flags (from registered count)
//               count           - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: an entry is only ever read while count says
  // it holds valid data.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Owns the single register-file write port. The in-order
//               writeback stage always wins the port; long-latency results
//               are buffered in a small FIFO and drained into free slots.
//               A per-register scoreboard marks destinations with a
//               long-latency result still outstanding so decode can stall,
//               and a starvation counter requests upstream bubbles when the
//               buffer cannot drain.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               wb_rd/wb_data/wb_regwen    - writeback-stage write request
//               ll_valid/ll_rd/ll_data     - long-latency result (in)
//               ll_ready                   - buffer can accept a result
//               issue_valid/issue_rd       - long-latency op dispatched
//               dec_rs1/dec_rs2/dec_rd     - decode registers to check
//               busy_stall                 - decode hazard stall
//               starve_stall               - upstream bubble request
//               rf_we/rf_rd/rf_wdata       - register-file write port
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import pipe_pkg::*;
#(
  // Must match the package data width, which sizes the write-request record.
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  wb_regwen,
  input  logic                  ll_valid,
  input  logic [REG_ADDR_W-1:0] ll_rd,
  input  logic [XLEN-1:0]       ll_data,
  output logic                  ll_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  output logic                  busy_stall,
  output logic                  starve_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int ENTRY_W = REG_ADDR_W + XLEN;
  localparam int SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic                  pipe_wr;
  logic                  drain;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  wb_req_t               wr_sel;

  logic [NUM_REGS-1:0]   sb_q, sb_d;
  logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic                  starve_stall_q, starve_stall_d;

  // --------------------------------------------------------------------------
  // Long-latency result buffer
  // --------------------------------------------------------------------------
  // Writes to x0 are architecturally void, so they are accepted and dropped
  // without using a buffer entry.
  assign ll_ready  = !fifo_full;
  assign fifo_push = ll_valid && ll_ready && (ll_rd != '0);

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({ll_rd, ll_data}),
    .pop       (drain),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_rd   = fifo_head[XLEN +: REG_ADDR_W];
  assign head_data = fifo_head[XLEN-1:0];

  // --------------------------------------------------------------------------
  // Write-port arbitration: pipeline first, buffer head in any free slot
  // --------------------------------------------------------------------------
  assign pipe_wr = wb_regwen && (wb_rd != '0);
  assign drain   = !pipe_wr && !fifo_empty;

  always_comb begin
    wr_sel = '0;
    if (pipe_wr) begin
      wr_sel.we   = 1'b1;
      wr_sel.rd   = wb_rd;
      wr_sel.data = wb_data;
    end else if (!fifo_empty) begin
      wr_sel.we   = 1'b1;
      wr_sel.rd   = head_rd;
      wr_sel.data = head_data;
    end
  end

  assign rf_we    = wr_sel.we;
  assign rf_rd    = wr_sel.rd;
  assign rf_wdata = wr_sel.data;

  // --------------------------------------------------------------------------
  // Outstanding-destination scoreboard
  // --------------------------------------------------------------------------
  // The set is applied after the clear so that a same-index collision keeps
  // the register marked busy.
  always_comb begin
    sb_d = sb_q;
    if (drain) begin
      sb_d[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      sb_d[issue_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Reading the registered scoreboard keeps a register busy through its own
  // drain-write cycle, so decode never needs a bypass from the write port.
  assign busy_stall = sb_q[dec_rs1] | sb_q[dec_rs2] | sb_q[dec_rd];

  // --------------------------------------------------------------------------
  // Starvation detection
  // --------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || drain) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  // A pop this cycle drops the request on the following cycle.
  assign starve_stall_d = !fifo_empty && !drain &&
                          (starve_cnt_q == SC_W'(STARVE_LIMIT));
  assign starve_stall   = starve_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q           <= '0;
      starve_cnt_q   <= '0;
      starve_stall_q <= 1'b0;
    end else begin
      sb_q           <= sb_d;
      starve_cnt_q   <= starve_cnt_d;
      starve_stall_q <= starve_stall_d;
    end
  end

  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_issue_free : assert property (@(posedge clk) disable iff (!rst_n)
    (issue_valid && (issue_rd != '0)) |-> !sb_q[issue_rd]);

  a_pipe_free : assert property (@(posedge clk) disable iff (!rst_n)
    pipe_wr |-> !sb_q[wb_rd]);

  a_ll_tracked : assert property (@(posedge clk) disable iff (!rst_n)
    (ll_valid && (ll_rd != '0)) |-> sb_q[ll_rd]);

  a_no_set_clear : assert property (@(posedge clk) disable iff (!rst_n)
    !(drain && issue_valid && (issue_rd != '0) && (issue_rd == head_rd)));

  a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CNT_W'(FIFO_DEPTH));
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. Per-cycle
//               vectors carry inputs and expected outputs; accepted
//               long-latency results are queued and compared against the
//               drain writes as they appear on the register-file port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_regwen;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        busy_stall;
  logic        starve_stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  regfile_wb_arbiter #(
    .XLEN         (32),
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_regwen    (wb_regwen),
    .ll_valid     (ll_valid),
    .ll_rd        (ll_rd),
    .ll_data      (ll_data),
    .ll_ready     (ll_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .busy_stall   (busy_stall),
    .starve_stall (starve_stall),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        llv;
    logic [4:0]  llrd;
    logic [31:0] lldat;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  drd;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_ready;
    logic        e_busy;
    logic        e_starve;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  int   errors = 0;
  int   checks = 0;
  wr_t  exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(
    input logic wen, input logic [4:0] wrd, input logic [31:0] wdat,
    input logic llv, input logic [4:0] llrd, input logic [31:0] lldat,
    input logic iv, input logic [4:0] ird,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] drd,
    input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_data,
    input logic e_ready, input logic e_busy, input logic e_starve);
    vec_t v;
    v.wen = wen;   v.wrd = wrd;   v.wdat = wdat;
    v.llv = llv;   v.llrd = llrd; v.lldat = lldat;
    v.iv = iv;     v.ird = ird;
    v.rs1 = rs1;   v.rs2 = rs2;   v.drd = drd;
    v.e_we = e_we; v.e_rd = e_rd; v.e_data = e_data;
    v.e_ready = e_ready; v.e_busy = e_busy; v.e_starve = e_starve;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    wb_regwen   = v.wen;  wb_rd   = v.wrd;  wb_data = v.wdat;
    ll_valid    = v.llv;  ll_rd   = v.llrd; ll_data = v.lldat;
    issue_valid = v.iv;   issue_rd = v.ird;
    dec_rs1     = v.rs1;  dec_rs2 = v.rs2;  dec_rd  = v.drd;
  endtask

  // Drive at posedge+1, compare at the falling edge, advance to posedge+1.
  task automatic apply(input string tag, input vec_t v);
    drive(v);
    @(negedge clk);
    chk({tag, ".rf_we"},        32'(rf_we),        32'(v.e_we));
    chk({tag, ".rf_rd"},        32'(rf_rd),        32'(v.e_rd));
    chk({tag, ".rf_wdata"},     rf_wdata,          v.e_data);
    chk({tag, ".ll_ready"},     32'(ll_ready),     32'(v.e_ready));
    chk({tag, ".busy_stall"},   32'(busy_stall),   32'(v.e_busy));
    chk({tag, ".starve_stall"}, 32'(starve_stall), 32'(v.e_starve));
    // Any write not owned by the pipeline must be the oldest queued result.
    if (rf_we && !(v.wen && v.wrd != 5'd0)) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".unexpected_drain"}, 32'(rf_rd), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk({tag, ".drain_rd"},   32'(rf_rd), 32'(e.rd));
        chk({tag, ".drain_data"}, rf_wdata,   e.data);
      end
    end
    if (v.llv && v.llrd != 5'd0 && v.e_ready) begin
      wr_t n;
      n.rd   = v.llrd;
      n.data = v.lldat;
      exp_q.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 1,0,0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- table: reset idle, basic drain, pipe priority, x0 results ----
    tbl.push_back(mk(0,0,0,        0,0,0,          0,0, 0,0,0,  0,0,0,          1,0,0));
    tbl.push_back(mk(0,0,0,        0,0,0,          1,5, 5,0,0,  0,0,0,          1,0,0));
    tbl.push_back(mk(0,0,0,        0,0,0,          0,0, 5,0,0,  0,0,0,          1,1,0));
    tbl.push_back(mk(0,0,0,        1,5,32'h1234,   0,0, 5,0,0,  0,0,0,          1,1,0));
    tbl.push_back(mk(0,0,0,        0,0,0,          0,0, 5,0,0,  1,5,32'h1234,   1,1,0));
    tbl.push_back(mk(0,0,0,        0,0,0,          0,0, 5,0,0,  0,0,0,          1,0,0));
    tbl.push_back(mk(1,3,32'hA,    0,0,0,          1,6, 0,6,0,  1,3,32'hA,      1,0,0));
    tbl.push_back(mk(1,3,32'hB,    1,6,32'h66,     0,0, 0,6,0,  1,3,32'hB,      1,1,0));
    tbl.push_back(mk(1,3,32'hC,    0,0,0,          0,0, 0,6,0,  1,3,32'hC,      1,1,0));
    tbl.push_back(mk(1,0,32'hDEAD, 0,0,0,          0,0, 0,6,0,  1,6,32'h66,     1,1,0));
    tbl.push_back(mk(0,0,0,        0,0,0,          0,0, 0,6,0,  0,0,0,          1,0,0));
    tbl.push_back(mk(0,0,0,        1,0,32'h77,     0,0, 0,0,0,  0,0,0,          1,0,0));
    tbl.push_back(mk(0,0,0,        0,0,0,          0,0, 0,0,0,  0,0,0,          1,0,0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // ---- starvation: two buffered results behind continuous pipe writes ----
    apply("st1", mk(1,1,32'h11, 0,0,0,          1,7, 7,0,0, 1,1,32'h11, 1,0,0));
    apply("st2", mk(1,1,32'h12, 0,0,0,          1,8, 7,0,0, 1,1,32'h12, 1,1,0));
    apply("st3", mk(1,1,32'h13, 1,7,32'h700,    0,0, 7,0,0, 1,1,32'h13, 1,1,0));
    apply("st4", mk(1,1,32'h14, 1,8,32'h800,    0,0, 7,0,0, 1,1,32'h14, 1,1,0));
    for (int k = 0; k < 11; k++) begin
      apply($sformatf("starve%0d", k),
            mk(1,1,32'h100 + 32'(k), 0,0,0, 0,0, 7,0,0,
               1,1,32'h100 + 32'(k), 0,1,(k >= 8)));
    end
    apply("st_free1", mk(0,0,0,       0,0,0, 0,0, 7,0,0, 1,7,32'h700, 0,1,1));
    apply("st_pipe",  mk(1,1,32'h200, 0,0,0, 0,0, 7,0,0, 1,1,32'h200, 1,0,0));
    apply("st_free2", mk(0,0,0,       0,0,0, 0,0, 7,0,0, 1,8,32'h800, 1,0,0));
    apply("st_idle",  mk(0,0,0,       0,0,0, 0,0, 7,0,0, 0,0,0,       1,0,0));

    // ---- asynchronous reset with buffered results and busy registers ----
    apply("rs1", mk(0,0,0,     0,0,0,        1,9,  9,10,11, 0,0,0,     1,0,0));
    apply("rs2", mk(0,0,0,     0,0,0,        1,10, 9,10,11, 0,0,0,     1,1,0));
    apply("rs3", mk(0,0,0,     0,0,0,        1,11, 9,10,11, 0,0,0,     1,1,0));
    apply("rs4", mk(1,1,32'h1, 1,9,32'h900,  0,0,  9,10,11, 1,1,32'h1, 1,1,0));
    apply("rs5", mk(1,1,32'h2, 1,10,32'hA00, 0,0,  9,10,11, 1,1,32'h2, 1,1,0));
    drive(mk(0,0,0, 0,0,0, 0,0, 9,10,11, 0,0,0, 0,0,0));
    #2;
    chk("pre_rst.rf_we",    32'(rf_we),    32'd1);
    chk("pre_rst.rf_rd",    32'(rf_rd),    32'd9);
    chk("pre_rst.ll_ready", 32'(ll_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst.rf_we",        32'(rf_we),        32'd0);
    chk("rst.rf_rd",        32'(rf_rd),        32'd0);
    chk("rst.rf_wdata",     rf_wdata,          32'd0);
    chk("rst.ll_ready",     32'(ll_ready),     32'd1);
    chk("rst.busy_stall",   32'(busy_stall),   32'd0);
    chk("rst.starve_stall", 32'(starve_stall), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply($sformatf("post_rst%0d", i),
            mk(0,0,0, 0,0,0, 0,0, 9,10,11, 0,0,0, 1,0,0));
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
